// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and WB operand forwarding and load-use detection.
// One cycle capture latency; stall holds every register, flush inserts a bubble.
module id_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [4:0]      id_rs1_addr,
   input  logic [4:0]      id_rs2_addr,
   input  logic [4:0]      id_rd_addr,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [3:0]      id_alu_decode,
   input  logic            id_use_imm,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_branch,
   input  logic [4:0]      exm_rd_addr,
   input  logic            exm_reg_write,
   input  logic [XLEN-1:0] exm_result,
   input  logic [4:0]      wb_rd_addr,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] rda,
   output logic [XLEN-1:0] rdx,
   output logic [3:0]      alu_decode,
   output logic [XLEN-1:0] store_data,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_branch,
   output logic [4:0]      ex_rd_addr,
   output logic            load_use_hazard
);

   localparam logic [3:0] ALU_ADD = 4'b0010;

   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm;
   logic            use_imm;

   // Data registers are left untouched by a flush; only the control bits matter for a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_branch    <= 1'b0;
         ex_rd_addr   <= 5'd0;
         alu_decode   <= ALU_ADD;
         rs1_addr     <= 5'd0;
         rs2_addr     <= 5'd0;
         rs1_data     <= '0;
         rs2_data     <= '0;
         imm          <= '0;
         use_imm      <= 1'b0;
      end else if (flush) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_branch    <= 1'b0;
         alu_decode   <= ALU_ADD;
      end else if (!stall) begin
         ex_valid     <= id_valid;
         ex_reg_write <= id_valid & id_reg_write;
         ex_mem_read  <= id_valid & id_mem_read;
         ex_branch    <= id_valid & id_branch;
         ex_rd_addr   <= id_rd_addr;
         alu_decode   <= id_alu_decode;
         rs1_addr     <= id_rs1_addr;
         rs2_addr     <= id_rs2_addr;
         rs1_data     <= id_rs1_data;
         rs2_data     <= id_rs2_data;
         imm          <= id_imm;
         use_imm      <= id_use_imm;
      end
   end

   // EX/MEM wins over WB; x0 is never forwarded.
   function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr, input logic [XLEN-1:0] data,
                                           input logic [4:0] e_rd, input logic e_we,
                                           input logic [XLEN-1:0] e_res, input logic [4:0] w_rd,
                                           input logic w_we, input logic [XLEN-1:0] w_dat);
      if (addr != 5'd0 && e_we && e_rd == addr) return e_res;
      if (addr != 5'd0 && w_we && w_rd == addr) return w_dat;
      return data;
   endfunction

   always_comb begin
      rda        = fwd(rs1_addr, rs1_data, exm_rd_addr, exm_reg_write, exm_result,
                       wb_rd_addr, wb_reg_write, wb_data);
      store_data = fwd(rs2_addr, rs2_data, exm_rd_addr, exm_reg_write, exm_result,
                       wb_rd_addr, wb_reg_write, wb_data);
      rdx        = use_imm ? imm : store_data;
   end

   assign load_use_hazard = ex_valid & ex_mem_read & (ex_rd_addr != 5'd0) & id_valid &
                            ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

endmodule
